// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, FSM
// states, ALU selects, instruction field positions, and the per-state
// control decode used by control_unit.
package cpu_pkg;

   // Instruction opcodes carried in IR[15:12]; 0110-1111 behave as NOOP.
   typedef enum logic [3:0] {
      OP_NOOP  = 4'd0,
      OP_STORE = 4'd1,
      OP_LOAD  = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_HALT  = 4'd5
   } opcode_t;

   // Sequencer states; the encoding is visible on state_out for debug.
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   // ALU operation selects.
   localparam logic [2:0] ALU_ZERO = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   // Instruction field positions.
   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 12;
   localparam int MADDR_HI = 11;
   localparam int MADDR_LO = 4;
   localparam int RA_HI    = 11;
   localparam int RA_LO    = 8;
   localparam int RB_HI    = 7;
   localparam int RB_LO    = 4;
   localparam int RD_HI    = 3;
   localparam int RD_LO    = 0;

   // Full set of control outputs driven towards the datapath and ROM.
   typedef struct packed {
      logic       i_rd;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] rf_w_addr;
      logic       rf_w_en;
      logic [3:0] rf_ra_addr;
      logic [3:0] rf_rb_addr;
      logic [2:0] alu_s;
   } ctrl_t;

   // Execute state entered from DECODE for a given opcode.
   function automatic state_t exec_state(input logic [3:0] op);
      state_t s;
      case (op)
         OP_STORE: s = S_STORE;
         OP_LOAD:  s = S_LOAD_A;
         OP_ADD:   s = S_ADD;
         OP_SUB:   s = S_SUB;
         OP_HALT:  s = S_HALT;
         default:  s = S_NOOP;
      endcase
      return s;
   endfunction

   // Next sequencer state; op only matters while in DECODE.
   function automatic state_t next_state(input state_t s, input logic [3:0] op);
      state_t n;
      case (s)
         S_INIT:   n = S_FETCH;
         S_FETCH:  n = S_DECODE;
         S_DECODE: n = exec_state(op);
         S_LOAD_A: n = S_LOAD_B;
         S_HALT:   n = S_HALT;
         default:  n = S_FETCH;
      endcase
      return n;
   endfunction

   // Control outputs for a state given the operand fields IR[11:0].
   // Everything defaults to zero; each state raises only what it needs.
   function automatic ctrl_t ctrl_decode(input state_t s, input logic [11:0] f);
      ctrl_t c;
      c = '0;
      c.alu_s = ALU_ZERO;
      case (s)
         S_FETCH: begin
            c.i_rd = 1'b1;
         end
         S_STORE: begin
            c.d_addr     = f[MADDR_HI:MADDR_LO];
            c.rf_ra_addr = f[RD_HI:RD_LO];
            c.d_wr       = 1'b1;
         end
         S_LOAD_A: begin
            c.d_addr = f[MADDR_HI:MADDR_LO];
         end
         S_LOAD_B: begin
            c.d_addr    = f[MADDR_HI:MADDR_LO];
            c.rf_s      = 1'b1;
            c.rf_w_addr = f[RD_HI:RD_LO];
            c.rf_w_en   = 1'b1;
         end
         S_ADD, S_SUB: begin
            c.rf_ra_addr = f[RA_HI:RA_LO];
            c.rf_rb_addr = f[RB_HI:RB_LO];
            c.rf_w_addr  = f[RD_HI:RD_LO];
            c.rf_s       = 1'b0;
            c.rf_w_en    = 1'b1;
            c.alu_s      = (s == S_ADD) ? ALU_ADD : ALU_SUB;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: PC_W-bit register with synchronous clear and an
// increment enable. Overflow wraps naturally from all-ones to zero.
module pc_counter #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Clear wins over increment; modular add gives the wrap.
   always_comb begin
      pc_d = pc_q;
      if (clr_i) begin
         pc_d = '0;
      end else if (inc_i) begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   // PC register.
   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Moore sequencer: fetches 16-bit instructions from a synchronous ROM,
// latches them into IR, and drives the datapath controls. All control
// outputs are registered together with the state so they always match
// state_out/IR_out, and I_data never reaches an output combinationally.
module control_unit #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] I_addr,
   output logic            I_rd,
   input  logic [15:0]     I_data,
   output logic [7:0]      D_Addr,
   output logic            D_wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_addr,
   output logic [3:0]      RF_Rb_addr,
   output logic [2:0]      Alu_s0,
   output logic [PC_W-1:0] PC_out,
   output logic [15:0]     IR_out,
   output logic [3:0]      state_out
);

   import cpu_pkg::*;

   state_t          state_q;
   state_t          state_d;
   logic [15:0]     ir_q;
   logic [15:0]     ir_d;
   ctrl_t           ctrl_q;
   logic [PC_W-1:0] pc;
   logic            pc_inc;

   // PC advances at the end of every FETCH cycle; reset clears it.
   assign pc_inc = (state_q == S_FETCH);

   pc_counter #(
      .PC_W (PC_W)
   ) u_pc (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (pc_inc),
      .pc_o  (pc)
   );

   // Next state and next IR; the ROM word is captured only in DECODE.
   assign state_d = next_state(state_q, I_data[OPC_HI:OPC_LO]);
   assign ir_d    = (state_q == S_DECODE) ? I_data : ir_q;

   // FSM: state, IR and the registered control outputs for the new state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         ir_q    <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctrl_q  <= ctrl_decode(state_d, ir_d[11:0]);
      end
   end

   assign I_addr     = pc;
   assign I_rd       = ctrl_q.i_rd;
   assign D_Addr     = ctrl_q.d_addr;
   assign D_wr       = ctrl_q.d_wr;
   assign RF_s       = ctrl_q.rf_s;
   assign RF_W_addr  = ctrl_q.rf_w_addr;
   assign RF_W_en    = ctrl_q.rf_w_en;
   assign RF_Ra_addr = ctrl_q.rf_ra_addr;
   assign RF_Rb_addr = ctrl_q.rf_rb_addr;
   assign Alu_s0     = ctrl_q.alu_s;
   assign PC_out     = pc;
   assign IR_out     = ir_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a directed vector table, hand-written sequences
// for HALT, PC wrap and reset during LOAD, and random programs checked
// cycle by cycle against an instruction-level trace model.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  I_addr;
   logic        I_rd;
   logic [15:0] I_data = 16'h0000;
   logic [7:0]  D_Addr;
   logic        D_wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  Alu_s0;
   logic [6:0]  PC_out;
   logic [15:0] IR_out;
   logic [3:0]  state_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] rom [128];

   control_unit #(.PC_W(7)) dut (
      .clk        (clk),
      .reset      (reset),
      .I_addr     (I_addr),
      .I_rd       (I_rd),
      .I_data     (I_data),
      .D_Addr     (D_Addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .Alu_s0     (Alu_s0),
      .PC_out     (PC_out),
      .IR_out     (IR_out),
      .state_out  (state_out)
   );

   always #5 clk = ~clk;

   // Synchronous instruction ROM: data valid the cycle after I_rd.
   always @(posedge clk) begin
      if (I_rd) I_data <= rom[I_addr];
   end

   typedef struct packed {
      logic [3:0]  st;
      logic [6:0]  iaddr;
      logic [6:0]  pc;
      logic [15:0] ir;
      logic        ird;
      logic [7:0]  da;
      logic        dw;
      logic        rs;
      logic [3:0]  wa;
      logic        we;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  alu;
   } obs_t;

   typedef struct {
      logic [15:0] instr;
      int          cyc;
      string       name;
      obs_t        exp;
   } vec_t;

   vec_t vq[$];
   obs_t exp_q[$];

   function automatic obs_t mk(input logic [3:0] st, input logic [6:0] pc,
                               input logic [15:0] ir, input logic ird,
                               input logic [7:0] da, input logic dw, input logic rs,
                               input logic [3:0] wa, input logic we,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic [2:0] alu);
      obs_t o;
      o.st = st; o.iaddr = pc; o.pc = pc; o.ir = ir; o.ird = ird;
      o.da = da; o.dw = dw; o.rs = rs; o.wa = wa; o.we = we;
      o.ra = ra; o.rb = rb; o.alu = alu;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st = state_out; o.iaddr = I_addr; o.pc = PC_out; o.ir = IR_out; o.ird = I_rd;
      o.da = D_Addr; o.dw = D_wr; o.rs = RF_s; o.wa = RF_W_addr; o.we = RF_W_en;
      o.ra = RF_Ra_addr; o.rb = RF_Rb_addr; o.alu = Alu_s0;
      return o;
   endfunction

   // Compares every output against an expected record; returns 1 on match.
   task automatic check(input string name, input obs_t exp, output bit ok);
      obs_t got;
      got = sample();
      n_cmp++;
      ok = (got === exp);
      if (!ok) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   // Holds reset over two edges, releases it; returns at cycle 0 (INIT).
   task automatic start_prog();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic add_vec(input logic [15:0] instr, input int cyc,
                          input string name, input obs_t exp);
      vec_t v;
      v.instr = instr; v.cyc = cyc; v.name = name; v.exp = exp;
      vq.push_back(v);
   endtask

   // Instruction-level model: expands the ROM program into the expected
   // per-cycle output trace, starting from the INIT cycle after reset.
   task automatic build_trace(input int n);
      logic [6:0]  pc;
      logic [15:0] ir;
      logic [15:0] ins;
      pc = 7'd0;
      ir = 16'h0000;
      exp_q.delete();
      exp_q.push_back(mk(4'd0, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      while (exp_q.size() < n) begin
         exp_q.push_back(mk(4'd1, pc, ir, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
         ins = rom[pc];
         pc  = pc + 7'd1;
         exp_q.push_back(mk(4'd2, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
         ir = ins;
         case (ir[15:12])
            4'd1: exp_q.push_back(mk(4'd6, pc, ir, 1'b0, ir[11:4], 1'b1, 1'b0, 4'd0, 1'b0, ir[3:0], 4'd0, 3'd0));
            4'd2: begin
               exp_q.push_back(mk(4'd4, pc, ir, 1'b0, ir[11:4], 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
               exp_q.push_back(mk(4'd5, pc, ir, 1'b0, ir[11:4], 1'b0, 1'b1, ir[3:0], 1'b1, 4'd0, 4'd0, 3'd0));
            end
            4'd3: exp_q.push_back(mk(4'd7, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'd1));
            4'd4: exp_q.push_back(mk(4'd8, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'd2));
            4'd5: begin
               while (exp_q.size() < n)
                  exp_q.push_back(mk(4'd9, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
            end
            default: exp_q.push_back(mk(4'd3, pc, ir, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
         endcase
      end
   endtask

   // Runs the current ROM from reset and compares n cycles against the model.
   task automatic run_trace(input string name, input int n);
      bit ok;
      build_trace(n);
      start_prog();
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("%s_c%0d", name, k), exp_q[k], ok);
         if (!ok) break;
      end
      $display("trace %s cycles=%0d", name, n);
   endtask

   initial begin
      bit ok;
      obs_t z;
      int   halt_bad;

      foreach (rom[j]) rom[j] = 16'h0000;

      // Directed table: one instruction at ROM[0], observed at cycle cyc.
      z = mk(4'd0, 7'd0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
      add_vec(16'h0000, 0, "noop_init",   z);
      add_vec(16'h0000, 1, "noop_fetch0", mk(4'd1, 7'd0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h0000, 2, "noop_decode", mk(4'd2, 7'd1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h0000, 3, "noop_exec",   mk(4'd3, 7'd1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h0000, 4, "noop_fetch1", mk(4'd1, 7'd1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h21B3, 3, "load_a",      mk(4'd4, 7'd1, 16'h21B3, 1'b0, 8'h1B, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h21B3, 4, "load_b",      mk(4'd5, 7'd1, 16'h21B3, 1'b0, 8'h1B, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 4'd0, 3'd0));
      add_vec(16'h21B3, 5, "load_fetch",  mk(4'd1, 7'd1, 16'h21B3, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h3123, 3, "add",         mk(4'd7, 7'd1, 16'h3123, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd1, 4'd2, 3'd1));
      add_vec(16'h3123, 4, "add_fetch",   mk(4'd1, 7'd1, 16'h3123, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h4334, 3, "sub",         mk(4'd8, 7'd1, 16'h4334, 1'b0, 8'h00, 1'b0, 1'b0, 4'd4, 1'b1, 4'd3, 4'd3, 3'd2));
      add_vec(16'h1802, 3, "store",       mk(4'd6, 7'd1, 16'h1802, 1'b0, 8'h80, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 4'd0, 3'd0));
      add_vec(16'h1802, 4, "store_after", mk(4'd1, 7'd1, 16'h1802, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h5000, 3, "halt",        mk(4'd9, 7'd1, 16'h5000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h5000, 30, "halt_stall", mk(4'd9, 7'd1, 16'h5000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'h7ABC, 3, "op7_noop",    mk(4'd3, 7'd1, 16'h7ABC, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      add_vec(16'hFFFF, 3, "opF_noop",    mk(4'd3, 7'd1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));

      for (int i = 0; i < vq.size(); i++) begin
         foreach (rom[j]) rom[j] = 16'h0000;
         rom[0] = vq[i].instr;
         start_prog();
         repeat (vq[i].cyc) @(negedge clk);
         check(vq[i].name, vq[i].exp, ok);
         $display("vec %0d %s instr=%h cyc=%0d", i, vq[i].name, vq[i].instr, vq[i].cyc);
      end

      // ADD then dependent SUB: back-to-back, 3 cycles per instruction.
      foreach (rom[j]) rom[j] = 16'h0000;
      rom[0] = 16'h3123;
      rom[1] = 16'h4334;
      run_trace("add_sub", 12);

      // HALT at ROM[5]: stalls with PC=6 and no fetches, reset recovers.
      foreach (rom[j]) rom[j] = 16'h0000;
      rom[5] = 16'h5000;
      start_prog();
      repeat (18) @(negedge clk);
      halt_bad = 0;
      for (int c = 0; c < 25; c++) begin
         if (!(state_out == 4'd9 && PC_out == 7'd6 && I_addr == 7'd6 && I_rd == 1'b0)) halt_bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (halt_bad != 0) begin
         n_bad++;
         $display("FAIL halt_hold bad_cycles=%0d want 0 (st=%0d pc=%0d)", halt_bad, state_out, PC_out);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("halt_reset", z, ok);
      $display("seq halt_hold");

      // PC wraps 127 -> 0 over 128+ NOOPs (FETCH k at cycle 1+3k).
      foreach (rom[j]) rom[j] = 16'h0000;
      start_prog();
      repeat (382) @(negedge clk);
      n_cmp++;
      if (!(state_out == 4'd1 && PC_out == 7'd127)) begin
         n_bad++;
         $display("FAIL wrap_pre st=%0d pc=%0d want st=1 pc=127", state_out, PC_out);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!(state_out == 4'd1 && PC_out == 7'd0 && I_addr == 7'd0)) begin
         n_bad++;
         $display("FAIL wrap_post st=%0d pc=%0d want st=1 pc=0", state_out, PC_out);
      end
      $display("seq pc_wrap");

      // Reset during LOAD_A: no write pulse, straight back to INIT.
      foreach (rom[j]) rom[j] = 16'h0000;
      rom[0] = 16'h21B3;
      start_prog();
      repeat (3) @(negedge clk);
      check("abort_load_a", mk(4'd4, 7'd1, 16'h21B3, 1'b0, 8'h1B, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0), ok);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_to_init", z, ok);
      @(negedge clk);
      check("abort_refetch", mk(4'd1, 7'd0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0), ok);
      $display("seq reset_in_load");

      // Random programs; HALT made rare so traces run long.
      for (int p = 0; p < 8; p++) begin
         for (int j = 0; j < 128; j++) begin
            logic [3:0]  op;
            logic [11:0] fld;
            op  = 4'($urandom_range(0, 15));
            fld = 12'($urandom);
            if (op == 4'd5 && $urandom_range(0, 7) != 0) op = 4'd2;
            rom[j] = {op, fld};
         end
         run_trace($sformatf("rand%0d", p), 200);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
